// File: rtl/spgd_pkg.sv
// Shared encodings for the SPGD iteration sequencer: FSM state codes
// (also exported on fsm_state for debug) and DAC value-source select codes.
package spgd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ARM   = 4'd1,
    ST_WR_P  = 4'd2,
    ST_SET_P = 4'd3,
    ST_INT_P = 4'd4,
    ST_WR_M  = 4'd5,
    ST_SET_M = 4'd6,
    ST_INT_M = 4'd7,
    ST_WR_U  = 4'd8
  } state_t;

  localparam logic [1:0] SEL_U_PLUS  = 2'b00;
  localparam logic [1:0] SEL_U_MINUS = 2'b01;
  localparam logic [1:0] SEL_U       = 2'b10;

endpackage

// File: rtl/spgd_metric_integrator.sv
// Sums INT_CYC consecutive signed samples while enabled; sum and a one-cycle done
// appear the cycle after the last sample. No backpressure: one sample per enabled cycle.
module spgd_metric_integrator #(
  parameter int INT_CYC = 64,
  parameter int ADC_W   = 14,
  parameter int ACC_W   = ADC_W + $clog2(INT_CYC)
) (
  input  logic             adc_clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [ADC_W-1:0] sample,
  output logic [ACC_W-1:0] sum,
  output logic             done,
  output logic             last
);

  localparam int CNT_W = $clog2(INT_CYC);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sample_ext;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;

  assign sample_ext = {{(ACC_W-ADC_W){sample[ADC_W-1]}}, sample};
  assign acc_next   = acc + sample_ext;
  assign last       = en && (cnt == CNT_W'(INT_CYC-1));

  // sum only moves on the final sample so it holds between measurements
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      sum  <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (en) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end
      if (last) sum <= acc_next;
    end
  end

endmodule

// File: rtl/spgd_iter_sequencer.sv
// SPGD iteration sequencer: on each trigger writes U+delta, measures J+, writes U-delta,
// measures J-, then commits U. DAC writes stall on dac_ready; all other phases are fixed-length.
module spgd_iter_sequencer
  import spgd_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int SETTLE_CYC = 16,
  parameter int INT_CYC    = 64,
  parameter int ADC_W      = 14
) (
  input  logic             adc_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             trig_in,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             dac_ready,
  output logic             dac_wr,
  output logic [3:0]       dac_ch,
  output logic [1:0]       dac_sel,
  output logic             jp_wr,
  output logic             jm_wr,
  output logic             u_wr,
  output logic [31:0]      j_sum,
  output logic             busy,
  output logic             trig_miss,
  output logic [3:0]       fsm_state
);

  localparam int ACC_W = ADC_W + $clog2(INT_CYC);

  state_t           state;
  state_t           state_next;
  logic             trig_s1, trig_s2, trig_s3;
  logic             trig_edge;
  logic [3:0]       ch;
  logic [9:0]       settle_cnt;
  logic             in_wr;
  logic             in_set;
  logic             xfer;
  logic             ch_last;
  logic             xfer_last;
  logic             settle_last;
  logic             int_clear;
  logic             int_en;
  logic             int_last;
  logic             int_done;
  logic [ACC_W-1:0] int_sum;

  assign trig_edge   = trig_s2 && !trig_s3;
  assign in_wr       = (state == ST_WR_P) || (state == ST_WR_M) || (state == ST_WR_U);
  assign in_set      = (state == ST_SET_P) || (state == ST_SET_M);
  assign xfer        = in_wr && dac_ready;
  assign ch_last     = (ch == 4'(N_CH-1));
  assign xfer_last   = xfer && ch_last;
  assign settle_last = in_set && (settle_cnt == 10'(SETTLE_CYC-1));

  always_ff @(posedge adc_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    dac_sel    = SEL_U_PLUS;
    int_clear  = 1'b0;
    int_en     = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = ST_ARM;
      ST_ARM: begin
        if (!start)         state_next = ST_IDLE;
        else if (trig_edge) state_next = ST_WR_P;
      end
      ST_WR_P: begin
        dac_sel = SEL_U_PLUS;
        if (xfer_last) state_next = ST_SET_P;
      end
      ST_SET_P: begin
        int_clear = 1'b1;
        if (settle_last) state_next = ST_INT_P;
      end
      ST_INT_P: begin
        int_en = 1'b1;
        if (int_last) state_next = ST_WR_M;
      end
      ST_WR_M: begin
        dac_sel = SEL_U_MINUS;
        if (xfer_last) state_next = ST_SET_M;
      end
      ST_SET_M: begin
        int_clear = 1'b1;
        if (settle_last) state_next = ST_INT_M;
      end
      ST_INT_M: begin
        int_en = 1'b1;
        if (int_last) state_next = ST_WR_U;
      end
      ST_WR_U: begin
        dac_sel = SEL_U;
        if (xfer_last) state_next = start ? ST_ARM : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // channel index wraps to 0 on the last transfer so every WR_* phase starts at ch 0
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      trig_s1    <= 1'b0;
      trig_s2    <= 1'b0;
      trig_s3    <= 1'b0;
      ch         <= '0;
      settle_cnt <= '0;
      trig_miss  <= 1'b0;
    end else begin
      trig_s1 <= trig_in;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
      if (xfer) ch <= ch_last ? 4'd0 : ch + 4'd1;
      if (in_set && !settle_last) settle_cnt <= settle_cnt + 10'd1;
      else                        settle_cnt <= '0;
      if (trig_edge && busy)                  trig_miss <= 1'b1;
      else if (state == ST_IDLE && !start)    trig_miss <= 1'b0;
    end
  end

  spgd_metric_integrator #(
    .INT_CYC (INT_CYC),
    .ADC_W   (ADC_W),
    .ACC_W   (ACC_W)
  ) u_integrator (
    .adc_clk (adc_clk),
    .rst     (rst),
    .clear   (int_clear),
    .en      (int_en),
    .sample  (adc_data),
    .sum     (int_sum),
    .done    (int_done),
    .last    (int_last)
  );

  // integration is always followed by a WR_* state, which tells J+ from J-
  assign jp_wr     = int_done && (state == ST_WR_M);
  assign jm_wr     = int_done && (state == ST_WR_U);
  assign u_wr      = xfer_last && (state == ST_WR_U);
  assign dac_wr    = in_wr;
  assign dac_ch    = ch;
  assign j_sum     = {{(32-ACC_W){int_sum[ACC_W-1]}}, int_sum};
  assign busy      = (state != ST_IDLE) && (state != ST_ARM);
  assign fsm_state = state;

endmodule
